// File: rtl/adder16_checker.sv
// Response checker for the adder16 interface: recomputes each accepted sample's result
// through a 2-stage pipeline, counts samples/mismatches and captures the first failure.
module adder16_checker #(
   parameter int WIDTH = 16,
   parameter int ERR_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             stop_on_err,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic [WIDTH-1:0] sum,
   input  logic             cout,
   output logic             busy,
   output logic             halted,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_cnt,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             first_valid,
   output logic [WIDTH-1:0] first_err_x,
   output logic [WIDTH-1:0] first_err_y,
   output logic [WIDTH-1:0] first_err_sum,
   output logic [1:0]       state_dbg
);

   // Handshake: a sample is taken on a rising edge when in_valid=1 and the checker is in RUN;
   // there is no back-pressure, so one sample per cycle is always accepted in RUN.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]   s1_x_q, s1_x_d;
   logic [WIDTH-1:0]   s1_y_q, s1_y_d;
   logic               s1_cin_q, s1_cin_d;
   logic [WIDTH-1:0]   s1_sum_q, s1_sum_d;
   logic               s1_cout_q, s1_cout_d;
   logic               mismatch_q, mismatch_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
   logic               first_valid_q, first_valid_d;
   logic [WIDTH-1:0]   first_x_q, first_x_d;
   logic [WIDTH-1:0]   first_y_q, first_y_d;
   logic [WIDTH-1:0]   first_sum_q, first_sum_d;

   logic [WIDTH:0]     exp_res;
   logic               s1_bad;

   assign exp_res = {1'b0, s1_x_q} + {1'b0, s1_y_q} + {{WIDTH{1'b0}}, s1_cin_q};
   assign s1_bad  = s1_valid_q && (exp_res != {s1_cout_q, s1_sum_q});

   always_comb begin
      state_d       = state_q;
      s1_valid_d    = 1'b0;
      s1_x_d        = s1_x_q;
      s1_y_d        = s1_y_q;
      s1_cin_d      = s1_cin_q;
      s1_sum_d      = s1_sum_q;
      s1_cout_d     = s1_cout_q;
      mismatch_d    = 1'b0;
      err_cnt_d     = err_cnt_q;
      sample_cnt_d  = sample_cnt_q;
      first_valid_d = first_valid_q;
      first_x_d     = first_x_q;
      first_y_d     = first_y_q;
      first_sum_d   = first_sum_q;

      if (start) begin
         // Start flushes stage 1 and drops any sample presented on this edge.
         state_d       = ST_RUN;
         err_cnt_d     = '0;
         sample_cnt_d  = '0;
         first_valid_d = 1'b0;
         first_x_d     = '0;
         first_y_d     = '0;
         first_sum_d   = '0;
      end else begin
         if (s1_valid_q) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (s1_bad) begin
               mismatch_d = 1'b1;
               if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + ERR_W'(1);
               end
               if (!first_valid_q) begin
                  first_valid_d = 1'b1;
                  first_x_d     = s1_x_q;
                  first_y_d     = s1_y_q;
                  first_sum_d   = s1_sum_q;
               end
            end
         end

         if (stop) begin
            state_d = ST_IDLE;
         end else if (state_q == ST_RUN) begin
            if (s1_bad && stop_on_err) begin
               state_d = ST_HALT;
            end
            // The halt decision is driven by stage 2, so this edge still accepts a sample.
            if (in_valid) begin
               s1_valid_d = 1'b1;
               s1_x_d     = x;
               s1_y_d     = y;
               s1_cin_d   = cin;
               s1_sum_d   = sum;
               s1_cout_d  = cout;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         s1_valid_q    <= 1'b0;
         s1_x_q        <= '0;
         s1_y_q        <= '0;
         s1_cin_q      <= 1'b0;
         s1_sum_q      <= '0;
         s1_cout_q     <= 1'b0;
         mismatch_q    <= 1'b0;
         err_cnt_q     <= '0;
         sample_cnt_q  <= '0;
         first_valid_q <= 1'b0;
         first_x_q     <= '0;
         first_y_q     <= '0;
         first_sum_q   <= '0;
      end else begin
         state_q       <= state_d;
         s1_valid_q    <= s1_valid_d;
         s1_x_q        <= s1_x_d;
         s1_y_q        <= s1_y_d;
         s1_cin_q      <= s1_cin_d;
         s1_sum_q      <= s1_sum_d;
         s1_cout_q     <= s1_cout_d;
         mismatch_q    <= mismatch_d;
         err_cnt_q     <= err_cnt_d;
         sample_cnt_q  <= sample_cnt_d;
         first_valid_q <= first_valid_d;
         first_x_q     <= first_x_d;
         first_y_q     <= first_y_d;
         first_sum_q   <= first_sum_d;
      end
   end

   assign busy          = (state_q == ST_RUN);
   assign halted        = (state_q == ST_HALT);
   assign mismatch      = mismatch_q;
   assign err_cnt       = err_cnt_q;
   assign sample_cnt    = sample_cnt_q;
   assign first_valid   = first_valid_q;
   assign first_err_x   = first_x_q;
   assign first_err_y   = first_y_q;
   assign first_err_sum = first_sum_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_adder16_checker.sv
// Bench for adder16_checker: directed vector table, hand-written multi-cycle sequences and
// a randomized phase compared every cycle against a queue-based reference model.
module tb_adder16_checker;

   localparam int WIDTH   = 16;
   localparam int ERR_W   = 8;
   localparam int CNT_W   = 8;
   localparam int SW      = 3 * WIDTH + 2;
   localparam int VW      = 6 + ERR_W + CNT_W + 3 * WIDTH;
   localparam int ERR_MAX = (1 << ERR_W) - 1;
   localparam int CNT_MOD = 1 << CNT_W;

   logic             clk = 1'b0;
   logic             rst_n, start, stop, stop_on_err, in_valid, cin, cout;
   logic [WIDTH-1:0] x, y, sum;
   logic             busy, halted, mismatch, first_valid;
   logic [ERR_W-1:0] err_cnt;
   logic [CNT_W-1:0] sample_cnt;
   logic [WIDTH-1:0] first_err_x, first_err_y, first_err_sum;
   logic [1:0]       state_dbg;

   int n_tests = 0;
   int n_fail  = 0;
   int mis_seen = 0;
   bit chk_en = 1'b0;

   adder16_checker #(.WIDTH(WIDTH), .ERR_W(ERR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .stop_on_err(stop_on_err),
      .in_valid(in_valid), .x(x), .y(y), .cin(cin), .sum(sum), .cout(cout),
      .busy(busy), .halted(halted), .mismatch(mismatch), .err_cnt(err_cnt),
      .sample_cnt(sample_cnt), .first_valid(first_valid), .first_err_x(first_err_x),
      .first_err_y(first_err_y), .first_err_sum(first_err_sum), .state_dbg(state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // exp_q holds accepted samples {x,y,cin,sum,cout} still in flight.
   logic [SW-1:0]    exp_q[$];
   int               m_mode;   // 0 idle, 1 run, 2 halt
   int               m_err, m_samples;
   bit               m_mis, m_first_v;
   logic [WIDTH-1:0] m_fx, m_fy, m_fsum;

   function automatic bit is_bad(input logic [SW-1:0] s);
      int a, b, c, so, co;
      a  = int'(s[SW-1 -: WIDTH]);
      b  = int'(s[2*WIDTH+1 -: WIDTH]);
      c  = int'(s[WIDTH+1]);
      so = int'(s[WIDTH -: WIDTH]);
      co = int'(s[0]);
      return (a + b + c) != (co * (1 << WIDTH) + so);
   endfunction

   always @(posedge clk) begin
      logic [SW-1:0] s;
      bit halt_req;
      halt_req = 1'b0;
      if (!rst_n || start) begin
         m_mode    = rst_n ? 1 : 0;
         exp_q.delete();
         m_err     = 0;
         m_samples = 0;
         m_mis     = 1'b0;
         m_first_v = 1'b0;
         m_fx      = '0;
         m_fy      = '0;
         m_fsum    = '0;
      end else begin
         m_mis = 1'b0;
         if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            m_samples = (m_samples + 1) % CNT_MOD;
            if (is_bad(s)) begin
               m_mis = 1'b1;
               if (m_err < ERR_MAX) m_err++;
               if (!m_first_v) begin
                  m_first_v = 1'b1;
                  m_fx      = s[SW-1 -: WIDTH];
                  m_fy      = s[2*WIDTH+1 -: WIDTH];
                  m_fsum    = s[WIDTH -: WIDTH];
               end
               if (m_mode == 1 && stop_on_err) halt_req = 1'b1;
            end
         end
         if (stop) begin
            m_mode = 0;
         end else begin
            if (m_mode == 1 && in_valid) exp_q.push_back({x, y, cin, sum, cout});
            if (halt_req) m_mode = 2;
         end
      end
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [VW-1:0] got_v, exp_v;
      if (chk_en) begin
         got_v = {state_dbg, busy, halted, mismatch, err_cnt, sample_cnt, first_valid,
                  first_err_x, first_err_y, first_err_sum};
         exp_v = {2'(m_mode), (m_mode == 1), (m_mode == 2), m_mis, ERR_W'(m_err),
                  CNT_W'(m_samples), m_first_v, m_fx, m_fy, m_fsum};
         n_tests++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL model @%0t: got %h expected %h", $time, got_v, exp_v);
         end
      end
      if (mismatch === 1'b1) mis_seen++;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- drivers (all changes on falling edges) ----------------
   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                       input logic [WIDTH-1:0] s, input logic co);
      x = a; y = b; cin = c; sum = s; cout = co; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_good(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] t;
      t = {1'b0, a} + {1'b0, b};
      send(a, b, 1'b0, t[WIDTH-1:0], t[WIDTH]);
   endtask

   task automatic send_bad(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] t;
      t = {1'b0, a} + {1'b0, b} + 17'd1;
      send(a, b, 1'b0, t[WIDTH-1:0], t[WIDTH]);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- test ----------------
   typedef struct {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             cin;
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             bad;
   } vec_t;

   vec_t vt[9];

   initial begin
      vt[0] = '{16'd100,  16'd300,  1'b0, 16'd400,  1'b0, 1'b0};
      vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
      vt[3] = '{16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
      vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[5] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0};
      vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vt[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[8] = '{16'h00FF, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1};

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; stop_on_err = 1'b0; in_valid = 1'b0;
      x = '0; y = '0; cin = 1'b0; sum = '0; cout = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      chk_en = 1'b1;
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_err", err_cnt, 0);
      check("rst_samples", sample_cnt, 0);
      check("rst_state", state_dbg, 0);

      // Single-sample vectors: latency 2 edges, one-cycle pulse.
      for (int i = 0; i < 9; i++) begin
         do_start();
         send(vt[i].x, vt[i].y, vt[i].cin, vt[i].sum, vt[i].cout);
         check($sformatf("vec%0d_latency", i), mismatch, 0);
         @(negedge clk);
         check($sformatf("vec%0d_mismatch", i), mismatch, vt[i].bad);
         check($sformatf("vec%0d_err", i), err_cnt, vt[i].bad);
         check($sformatf("vec%0d_samples", i), sample_cnt, 1);
         check($sformatf("vec%0d_first_valid", i), first_valid, vt[i].bad);
         @(negedge clk);
         check($sformatf("vec%0d_pulse_end", i), mismatch, 0);
      end

      // Stream of 20 with the 5th reporting sum+1.
      do_start();
      mis_seen = 0;
      for (int i = 0; i < 20; i++) begin
         logic [WIDTH-1:0] a, b, s;
         a = 16'(1000 + 100 * i);
         b = 16'(2000 + 300 * i);
         s = a + b + ((i == 4) ? 16'd1 : 16'd0);
         send(a, b, 1'b0, s, 1'b0);
      end
      wait_cyc(3);
      check("stream_pulses", mis_seen, 1);
      check("stream_err", err_cnt, 1);
      check("stream_samples", sample_cnt, 20);
      check("stream_first_valid", first_valid, 1);
      check("stream_first_x", first_err_x, 16'd1400);
      check("stream_first_y", first_err_y, 16'd3200);
      check("stream_first_sum", first_err_sum, 16'd4601);

      // Halt on error: sample 3 wrong, sample 4 still completes.
      stop_on_err = 1'b1;
      do_start();
      for (int i = 1; i <= 6; i++) begin
         x = 16'(i * 7); y = 16'(i * 11); cin = 1'b0; cout = 1'b0;
         sum = 16'(i * 18 + ((i == 3) ? 1 : 0));
         in_valid = 1'b1;
         @(negedge clk);
         if (i == 4) begin
            check("halt_at_stage2", halted, 1);
            check("halt_busy", busy, 0);
         end
      end
      in_valid = 1'b0;
      wait_cyc(2);
      check("halt_samples", sample_cnt, 4);
      check("halt_err", err_cnt, 1);
      check("halt_first_x", first_err_x, 16'd21);
      check("halt_first_sum", first_err_sum, 16'd55);
      check("halt_state", state_dbg, 2);
      for (int i = 0; i < 3; i++) send_bad(16'(i), 16'(i));
      wait_cyc(2);
      check("halt_frozen", sample_cnt, 4);
      do_start();
      check("restart_busy", busy, 1);
      check("restart_halted", halted, 0);
      check("restart_samples", sample_cnt, 0);
      check("restart_err", err_cnt, 0);
      check("restart_first_valid", first_valid, 0);
      stop_on_err = 1'b0;
      do_stop();

      // Stop while a bad sample is in stage 1; the sample on the stop edge is dropped.
      do_start();
      send_bad(16'h0010, 16'h0020);
      stop = 1'b1;
      x = 16'd1; y = 16'd1; sum = 16'd2; cout = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      stop = 1'b0; in_valid = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_mismatch", mismatch, 1);
      check("stop_err", err_cnt, 1);
      wait_cyc(2);
      check("stop_samples", sample_cnt, 1);

      // Saturation and wrap.
      do_start();
      for (int i = 0; i < 300; i++) send_bad(16'($urandom), 16'($urandom));
      wait_cyc(2);
      check("sat_err", err_cnt, ERR_MAX);
      check("sat_samples", sample_cnt, 300 % CNT_MOD);
      do_start();
      for (int i = 0; i < CNT_MOD + 1; i++) send_good(16'($urandom), 16'($urandom));
      wait_cyc(2);
      check("wrap_samples", sample_cnt, 1);
      check("wrap_err", err_cnt, 0);

      // Reset one cycle after accepting a failing sample.
      do_start();
      send_bad(16'h1234, 16'h4321);
      mis_seen = 0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_mismatch", mismatch, 0);
      check("midrst_busy", busy, 0);
      check("midrst_state", state_dbg, 0);
      check("midrst_first_valid", first_valid, 0);
      for (int i = 0; i < 3; i++) send_bad(16'(i), 16'(i + 1));
      wait_cyc(2);
      check("midrst_ignored", sample_cnt, 0);
      check("midrst_err", err_cnt, 0);
      check("midrst_no_pulse", mis_seen, 0);

      // Randomized traffic against the model.
      do_start();
      for (int i = 0; i < 800; i++) begin
         logic [WIDTH:0] t;
         x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom);
         t = {1'b0, x} + {1'b0, y} + {16'd0, cin};
         if ($urandom_range(0, 7) == 0) t = t ^ (17'd1 << $urandom_range(0, 16));
         {cout, sum} = t;
         in_valid = ($urandom_range(0, 3) != 0);
         start = ($urandom_range(0, 60) == 0);
         stop = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 40) == 0) stop_on_err = ~stop_on_err;
         @(negedge clk);
      end
      in_valid = 1'b0; start = 1'b0; stop = 1'b0;
      wait_cyc(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
